// File: rtl/convolution_3x3_if.sv
// Pixel stream bundle between the line buffer, the 3x3 convolution and the downstream consumer.
// data_in[0] is the top row of the column and data_in[2] is the bottom row.
interface convolution_3x3_if;
  logic [2:0][15:0] data_in;
  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic             data_valid_in;
  logic [15:0]      pixel_data_out;
  logic [10:0]      hcount_out;
  logic [9:0]       vcount_out;
  logic             data_valid_out;

  modport slave (
    input  data_in, hcount_in, vcount_in, data_valid_in,
    output pixel_data_out, hcount_out, vcount_out, data_valid_out
  );

  modport master (
    output data_in, hcount_in, vcount_in, data_valid_in,
    input  pixel_data_out, hcount_out, vcount_out, data_valid_out
  );
endinterface

// File: rtl/convolution_3x3.sv
// 3x3 RGB565 window convolution with a fixed kernel chosen by K_SELECT.
// Three register stages: window and centre tags, per-channel MAC, then shift/clamp/pack.
module convolution_3x3 #(
  parameter int HRES     = 1280,
  parameter int VRES     = 720,
  parameter int K_SELECT = 1
) (
  input logic               clk_in,
  input logic               rst_n_in,
  convolution_3x3_if.slave  bus
);
  localparam int SHIFT = (K_SELECT == 1) ? 4 : 0;

  // idx = row*3 + col; odd indices are the four edge neighbours, even non-centre are corners
  function automatic logic signed [7:0] coef(input int idx);
    logic signed [7:0] c;
    case (K_SELECT)
      1:       c = (idx == 4) ? 8'sd4 : ((idx % 2) == 1) ? 8'sd2 : 8'sd1;
      2:       c = (idx == 4) ? 8'sd5 : ((idx % 2) == 1) ? -8'sd1 : 8'sd0;
      3:       c = (idx == 4) ? 8'sd8 : -8'sd1;
      default: c = (idx == 4) ? 8'sd1 : 8'sd0;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] chan(input logic [15:0] p, input int ch);
    case (ch)
      0:       return {1'b0, p[15:11]};
      1:       return p[10:5];
      default: return {1'b0, p[4:0]};
    endcase
  endfunction

  function automatic logic [5:0] clamp(input logic signed [15:0] acc, input logic [5:0] top);
    logic signed [15:0] s;
    s = acc >>> SHIFT;
    if (s < 16'sd0) return 6'd0;
    if (s > $signed({10'd0, top})) return top;
    return s[5:0];
  endfunction

  logic [15:0]        win [3][3];  // [column][row], column 2 is the newest
  logic [10:0]        hc_new, s1_hc, s2_hc;
  logic [9:0]         v_next, vc_new, s1_vc, s2_vc;
  logic               s1_valid, s2_valid, s2_border;
  logic [15:0]        s2_centre;
  logic signed [15:0] mac [3];
  logic signed [15:0] s2_mac [3];
  logic [5:0]         r_cl, g_cl, b_cl;

  // Column hcount_in==0 closes the window on the previous line's last column
  always_comb begin
    v_next = (bus.vcount_in == 10'(VRES - 1)) ? 10'd0 : bus.vcount_in + 10'd1;
    if (bus.hcount_in == 11'd0) begin
      hc_new = 11'(HRES - 1);
      vc_new = (v_next == 10'd0) ? 10'(VRES - 1) : v_next - 10'd1;
    end else begin
      hc_new = bus.hcount_in - 11'd1;
      vc_new = v_next;
    end
  end

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      mac[ch] = '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          mac[ch] = mac[ch] + 16'(coef(r * 3 + c)) * $signed({10'd0, chan(win[c][r], ch)});
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) win[c][r] <= '0;
      end
      s1_hc    <= '0;
      s1_vc    <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= bus.data_valid_in;
      if (bus.data_valid_in) begin
        for (int r = 0; r < 3; r++) begin
          win[0][r] <= win[1][r];
          win[1][r] <= win[2][r];
          win[2][r] <= bus.data_in[r];
        end
        s1_hc <= hc_new;
        s1_vc <= vc_new;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int ch = 0; ch < 3; ch++) s2_mac[ch] <= '0;
      s2_hc     <= '0;
      s2_vc     <= '0;
      s2_centre <= '0;
      s2_border <= 1'b0;
      s2_valid  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        for (int ch = 0; ch < 3; ch++) s2_mac[ch] <= mac[ch];
        s2_hc     <= s1_hc;
        s2_vc     <= s1_vc;
        s2_centre <= win[1][1];
        s2_border <= (s1_hc == 11'd0) || (s1_hc == 11'(HRES - 1)) ||
                     (s1_vc == 10'd0) || (s1_vc == 10'(VRES - 1));
      end
    end
  end

  assign r_cl = clamp(s2_mac[0], 6'd31);
  assign g_cl = clamp(s2_mac[1], 6'd63);
  assign b_cl = clamp(s2_mac[2], 6'd31);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.pixel_data_out <= '0;
      bus.hcount_out     <= '0;
      bus.vcount_out     <= '0;
      bus.data_valid_out <= 1'b0;
    end else begin
      bus.data_valid_out <= s2_valid;
      if (s2_valid) begin
        bus.pixel_data_out <= s2_border ? s2_centre : {r_cl[4:0], g_cl, b_cl[4:0]};
        bus.hcount_out     <= s2_hc;
        bus.vcount_out     <= s2_vc;
      end
    end
  end
endmodule
